// File: rtl/fp_wire.sv
// Shared types and constants for fp_unit regression checking.
package fp_wire;

  // One expected result as pushed at issue time.
  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  flags;
    logic [1:0]  fmt;
    logic        cmp;
    logic        f2i;
    logic        finish;
  } fp_check_entry;

  // Canonical quiet NaNs produced by fp_unit (single, double).
  localparam logic [31:0] FP_NAN_S = 32'h7FC0_0000;
  localparam logic [63:0] FP_NAN_D = 64'h7FF8_0000_0000_0000;

endpackage

// File: rtl/fp_check_fifo.sv
// In-order synchronous FIFO holding expected entries. push/pop are strobes
// already qualified by the caller; a pop and push in the same cycle on a
// full FIFO is legal because the pop frees the slot being written.
module fp_check_fifo #(
  parameter int  DEPTH   = 8,
  parameter type entry_t = logic
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB is the wrap bit that tells full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer advance; reset empties the FIFO without touching storage.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Entry storage, written at the tail.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fp_check_scoreboard.sv
// Expected-result scoreboard for fp_unit benches: queues expected entries
// at issue, retires one per DUT ready, compares with canonical-NaN masking
// and keeps pass/fail statistics plus sticky status flags.
module fp_check_scoreboard
  import fp_wire::*;
#(
  parameter int DEPTH        = 8,
  parameter int CNT_W        = 32,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic             reset,
  input  logic             clock,
  input  logic             issue_valid,
  input  fp_check_entry    issue_entry,
  input  logic             ready_calc,
  input  logic [63:0]      result_calc,
  input  logic [4:0]       flags_calc,
  output logic             fail_valid,
  output logic [63:0]      fail_result_diff,
  output logic [4:0]       fail_flags_diff,
  output logic [CNT_W-1:0] fail_index,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             overflow,
  output logic             underflow,
  output logic             stopped,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  fp_check_entry    head;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;
  logic [63:0]      result_diff;
  logic [4:0]       flags_diff;
  logic             mismatch;
  logic [CNT_W-1:0] retire_ord;

  // No bypass: a retire on an empty FIFO never sees the same-cycle push.
  assign do_pop  = ready_calc && !empty && !stopped;
  assign do_push = issue_valid && !stopped && (!full || do_pop);

  fp_check_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fp_check_entry)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (do_push),
    .push_data (issue_entry),
    .pop       (do_pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Result diff; a canonical NaN from the DUT only needs to agree on the
  // exponent and quiet bit, since payloads of the expected NaN may differ.
  always_comb begin
    result_diff = result_calc ^ head.result;
    if (!head.cmp && !head.f2i) begin
      if (head.fmt == 2'd0) begin
        if (result_calc[31:0] == FP_NAN_S)
          result_diff = {32'h0, 1'b0, result_calc[30:22] ^ head.result[30:22], 22'h0};
      end else if (result_calc == FP_NAN_D) begin
        result_diff = {1'b0, result_calc[62:51] ^ head.result[62:51], 51'h0};
      end
    end
  end

  assign flags_diff = flags_calc ^ head.flags;
  assign mismatch   = (result_diff != 64'h0) || (flags_diff != 5'h0);

  // Retire bookkeeping, report registers and sticky status.
  always_ff @(posedge clock) begin
    if (reset) begin
      fail_valid       <= 1'b0;
      fail_result_diff <= '0;
      fail_flags_diff  <= '0;
      fail_index       <= '0;
      pass_count       <= '0;
      fail_count       <= '0;
      retire_ord       <= '0;
      overflow         <= 1'b0;
      underflow        <= 1'b0;
      stopped          <= 1'b0;
      done             <= 1'b0;
    end else begin
      fail_valid <= 1'b0;
      if (do_pop) begin
        if (mismatch) begin
          fail_valid       <= 1'b1;
          fail_result_diff <= result_diff;
          fail_flags_diff  <= flags_diff;
          fail_index       <= retire_ord;
          if (fail_count != CNT_MAX) fail_count <= fail_count + CNT_W'(1);
          if (STOP_ON_FAIL != 0) stopped <= 1'b1;
        end else if (pass_count != CNT_MAX) begin
          pass_count <= pass_count + CNT_W'(1);
        end
        if (retire_ord != CNT_MAX) retire_ord <= retire_ord + CNT_W'(1);
        if (head.finish) done <= 1'b1;
      end
      if (ready_calc && empty && !stopped) underflow <= 1'b1;
      if (issue_valid && full && !do_pop && !stopped) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_check_scoreboard.sv
// Bench for fp_check_scoreboard: two instances (freeze-on-fail and
// keep-checking) share one stimulus stream and are compared every cycle
// against a queue-based reference model of the scoreboard behaviour.
module tb_fp_check_scoreboard;
  import fp_wire::*;

  localparam int DEPTH = 8;

  logic          clock;
  logic          reset;
  logic          issue_valid;
  fp_check_entry issue_entry;
  logic          ready_calc;
  logic [63:0]   result_calc;
  logic [4:0]    flags_calc;

  logic        fv0, ov0, un0, st0, dn0, fv1, ov1, un1, st1, dn1;
  logic [63:0] rd0, rd1;
  logic [4:0]  fd0, fd1;
  logic [31:0] fi0, pc0, fc0, fi1, pc1, fc1;

  int tests = 0;
  int failed = 0;
  int fv_seen [2];

  // reference model state, index 0 = stop-on-fail, 1 = keep-checking
  fp_check_entry mq [2][$];
  int          m_pass [2], m_fail [2], m_ord [2], m_idx [2];
  logic        m_fv [2], m_ov [2], m_un [2], m_st [2], m_dn [2];
  logic [63:0] m_rd [2];
  logic [4:0]  m_fd [2];

  fp_check_scoreboard #(.DEPTH(DEPTH), .CNT_W(32), .STOP_ON_FAIL(1)) dut (
    .reset(reset), .clock(clock), .issue_valid(issue_valid), .issue_entry(issue_entry),
    .ready_calc(ready_calc), .result_calc(result_calc), .flags_calc(flags_calc),
    .fail_valid(fv0), .fail_result_diff(rd0), .fail_flags_diff(fd0), .fail_index(fi0),
    .pass_count(pc0), .fail_count(fc0), .overflow(ov0), .underflow(un0),
    .stopped(st0), .done(dn0));

  fp_check_scoreboard #(.DEPTH(DEPTH), .CNT_W(32), .STOP_ON_FAIL(0)) dut_ns (
    .reset(reset), .clock(clock), .issue_valid(issue_valid), .issue_entry(issue_entry),
    .ready_calc(ready_calc), .result_calc(result_calc), .flags_calc(flags_calc),
    .fail_valid(fv1), .fail_result_diff(rd1), .fail_flags_diff(fd1), .fail_index(fi1),
    .pass_count(pc1), .fail_count(fc1), .overflow(ov1), .underflow(un1),
    .stopped(st1), .done(dn1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected diff straight from the masking rules, expressed as bit masks.
  function automatic logic [63:0] ref_diff(input fp_check_entry e, input logic [63:0] rc);
    logic [63:0] x;
    x = rc ^ e.result;
    if (!e.cmp && !e.f2i && e.fmt == 2'd0 && rc[31:0] == 32'h7FC0_0000)
      return x & 64'h0000_0000_7FC0_0000;
    if (!e.cmp && !e.f2i && e.fmt != 2'd0 && rc == 64'h7FF8_0000_0000_0000)
      return x & 64'h7FF8_0000_0000_0000;
    return x;
  endfunction

  task automatic model_step(input int k, input logic rst, input logic iv, input fp_check_entry ie,
                            input logic rv, input logic [63:0] rc, input logic [4:0] fc);
    fp_check_entry e;
    logic [63:0] d;
    logic [4:0] fdl;
    m_fv[k] = 1'b0;
    if (rst) begin
      mq[k].delete();
      m_pass[k] = 0; m_fail[k] = 0; m_ord[k] = 0; m_idx[k] = 0;
      m_ov[k] = 0; m_un[k] = 0; m_st[k] = 0; m_dn[k] = 0; m_rd[k] = '0; m_fd[k] = '0;
      return;
    end
    if (m_st[k]) return;
    if (rv && mq[k].size() == 0) m_un[k] = 1'b1;
    if (rv && mq[k].size() > 0) begin
      e = mq[k].pop_front();
      d = ref_diff(e, rc);
      fdl = fc ^ e.flags;
      if (d == 64'h0 && fdl == 5'h0) m_pass[k]++;
      else begin
        m_fail[k]++;
        m_fv[k] = 1'b1; m_rd[k] = d; m_fd[k] = fdl; m_idx[k] = m_ord[k];
        if (k == 0) m_st[k] = 1'b1;
      end
      m_ord[k]++;
      if (e.finish) m_dn[k] = 1'b1;
    end
    if (iv) begin
      if (mq[k].size() < DEPTH) mq[k].push_back(ie);
      else m_ov[k] = 1'b1;
    end
  endtask

  task automatic cmp_dut(input int k, input logic fv, input logic [63:0] rd, input logic [4:0] fd,
                         input logic [31:0] fi, input logic [31:0] pc, input logic [31:0] fc,
                         input logic ov, input logic un, input logic st, input logic dn);
    chk($sformatf("fail_valid[%0d]", k), 64'(fv), 64'(m_fv[k]));
    chk($sformatf("fail_result_diff[%0d]", k), rd, m_rd[k]);
    chk($sformatf("fail_flags_diff[%0d]", k), 64'(fd), 64'(m_fd[k]));
    chk($sformatf("fail_index[%0d]", k), 64'(fi), 64'(m_idx[k]));
    chk($sformatf("pass_count[%0d]", k), 64'(pc), 64'(m_pass[k]));
    chk($sformatf("fail_count[%0d]", k), 64'(fc), 64'(m_fail[k]));
    chk($sformatf("overflow[%0d]", k), 64'(ov), 64'(m_ov[k]));
    chk($sformatf("underflow[%0d]", k), 64'(un), 64'(m_un[k]));
    chk($sformatf("stopped[%0d]", k), 64'(st), 64'(m_st[k]));
    chk($sformatf("done[%0d]", k), 64'(dn), 64'(m_dn[k]));
    if (fv) fv_seen[k]++;
  endtask

  // One clock: drive at negedge, model at posedge, check 1 time unit later.
  task automatic step(input logic rst, input logic iv, input fp_check_entry ie,
                      input logic rv, input logic [63:0] rc, input logic [4:0] fc);
    reset = rst; issue_valid = iv; issue_entry = ie;
    ready_calc = rv; result_calc = rc; flags_calc = fc;
    @(posedge clock);
    model_step(0, rst, iv, ie, rv, rc, fc);
    model_step(1, rst, iv, ie, rv, rc, fc);
    #1;
    cmp_dut(0, fv0, rd0, fd0, fi0, pc0, fc0, ov0, un0, st0, dn0);
    cmp_dut(1, fv1, rd1, fd1, fi1, pc1, fc1, ov1, un1, st1, dn1);
    @(negedge clock);
  endtask

  function automatic fp_check_entry rand_entry();
    fp_check_entry e;
    e.result = {$urandom, $urandom};
    e.flags  = 5'($urandom_range(0, 31));
    e.fmt    = 2'($urandom_range(0, 3));
    e.cmp    = 1'($urandom_range(0, 1));
    e.f2i    = 1'($urandom_range(0, 1));
    e.finish = 1'b0;
    return e;
  endfunction

  task automatic do_reset();
    step(1'b1, 1'b0, '0, 1'b0, 64'h0, 5'h0);
    fv_seen[0] = 0;
    fv_seen[1] = 0;
  endtask

  // Issue n ops with alternating latencies, results returned in order;
  // op k is made a flags mismatch (exp 0x01, calc 0x00) when bad_sel[k].
  task automatic run_ops(input int n, input int lat_a, input int lat_b, input int max_out,
                         input logic [31:0] bad_sel);
    fp_check_entry calc_q[$];
    int due_q[$];
    fp_check_entry e, c, ie;
    int issued = 0, retired = 0, cyc = 0, last_due = -1, outst, d;
    logic iv, rv;
    logic [63:0] rc;
    logic [4:0] fc;
    while (retired < n && cyc < 2000) begin
      outst = issued - retired;
      iv = 1'b0; ie = '0; rv = 1'b0; rc = 64'h0; fc = 5'h0;
      if (due_q.size() > 0) begin
        if (due_q[0] <= cyc) begin
          void'(due_q.pop_front());
          c = calc_q.pop_front();
          rv = 1'b1; rc = c.result; fc = c.flags;
          retired++;
        end
      end
      if (issued < n && outst < max_out) begin
        e = rand_entry();
        e.finish = (issued == n - 1);
        c = e;
        if (bad_sel[issued]) begin
          e.flags = 5'h01;
          c.flags = 5'h00;
        end
        d = cyc + (((issued % 2) == 1) ? lat_b : lat_a);
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        due_q.push_back(d);
        calc_q.push_back(c);
        issued++;
        iv = 1'b1; ie = e;
      end
      step(1'b0, iv, ie, rv, rc, fc);
      cyc++;
    end
    if (cyc >= 2000) chk("run_ops_timeout", 64'(retired), 64'(n));
  endtask

  fp_check_entry fill [DEPTH];
  fp_check_entry ea;

  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_entry = '0;
    ready_calc = 1'b0; result_calc = 64'h0; flags_calc = 5'h0;
    fv_seen[0] = 0; fv_seen[1] = 0;

    // reset state
    do_reset();
    chk("reset_pass", 64'(pc0), 64'd0);
    chk("reset_done", 64'(dn0), 64'd0);

    // fixed latency 4, ten matching ops
    run_ops(10, 4, 4, DEPTH, 32'h0);
    step(1'b0, 1'b0, '0, 1'b0, 64'h0, 5'h0);
    chk("fixed_pass", 64'(pc0), 64'd10);
    chk("fixed_fail", 64'(fc0), 64'd0);
    chk("fixed_done", 64'(dn0), 64'd1);
    chk("fixed_pulses", 64'(fv_seen[0]), 64'd0);

    // variable latency 1 / 20, up to DEPTH outstanding
    do_reset();
    run_ops(16, 1, 20, DEPTH, 32'h0);
    step(1'b0, 1'b0, '0, 1'b0, 64'h0, 5'h0);
    chk("varlat_pass", 64'(pc0), 64'd16);
    chk("varlat_ovf", 64'(ov0), 64'd0);
    chk("varlat_unf", 64'(un0), 64'd0);
    chk("varlat_done", 64'(dn0), 64'd1);

    // canonical NaN masking
    do_reset();
    ea = '0; ea.result = 64'h0000_0000_7FC0_0001;
    step(1'b0, 1'b1, ea, 1'b0, 64'h0, 5'h0);
    step(1'b0, 1'b0, '0, 1'b1, 64'h0000_0000_7FC0_0000, 5'h0);
    ea = '0; ea.fmt = 2'd1; ea.result = 64'h7FF8_0000_0000_0001;
    step(1'b0, 1'b1, ea, 1'b0, 64'h0, 5'h0);
    step(1'b0, 1'b0, '0, 1'b1, 64'h7FF8_0000_0000_0000, 5'h0);
    chk("nan_pass", 64'(pc0), 64'd2);
    chk("nan_fail", 64'(fc0), 64'd0);
    ea = '0; ea.cmp = 1'b1; ea.result = 64'h0000_0000_7FC0_0001;
    step(1'b0, 1'b1, ea, 1'b0, 64'h0, 5'h0);
    step(1'b0, 1'b0, '0, 1'b1, 64'h0000_0000_7FC0_0000, 5'h0);
    chk("nan_cmp_fv", 64'(fv0), 64'd1);
    chk("nan_cmp_diff", rd0, 64'h1);
    step(1'b0, 1'b0, '0, 1'b0, 64'h0, 5'h0);
    chk("nan_fv_pulse", 64'(fv0), 64'd0);
    chk("nan_diff_hold", rd0, 64'h1);

    // flags mismatch on 3rd retirement
    do_reset();
    run_ops(6, 4, 4, DEPTH, 32'h4);
    step(1'b0, 1'b0, '0, 1'b0, 64'h0, 5'h0);
    chk("flag_pulses", 64'(fv_seen[0]), 64'd1);
    chk("flag_index", 64'(fi0), 64'd2);
    chk("flag_fdiff", 64'(fd0), 64'h01);
    chk("flag_stopped", 64'(st0), 64'd1);
    chk("flag_frozen_pass", 64'(pc0), 64'd2);
    chk("flag_no_done", 64'(dn0), 64'd0);
    chk("flag_ns_pass", 64'(pc1), 64'd5);

    // keep-checking mode, two failures among six
    do_reset();
    run_ops(6, 1, 3, DEPTH, 32'h12);
    step(1'b0, 1'b0, '0, 1'b0, 64'h0, 5'h0);
    chk("ns_fail", 64'(fc1), 64'd2);
    chk("ns_pass", 64'(pc1), 64'd4);
    chk("ns_done", 64'(dn1), 64'd1);
    chk("ns_stopped", 64'(st1), 64'd0);

    // fill then push once more
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      fill[i] = rand_entry();
      step(1'b0, 1'b1, fill[i], 1'b0, 64'h0, 5'h0);
    end
    chk("full_no_ovf", 64'(ov0), 64'd0);
    step(1'b0, 1'b1, rand_entry(), 1'b0, 64'h0, 5'h0);
    chk("full_ovf", 64'(ov0), 64'd1);

    // push + pop while full
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      fill[i] = rand_entry();
      step(1'b0, 1'b1, fill[i], 1'b0, 64'h0, 5'h0);
    end
    step(1'b0, 1'b1, rand_entry(), 1'b1, fill[0].result, fill[0].flags);
    chk("fullpp_ovf", 64'(ov0), 64'd0);
    chk("fullpp_pass", 64'(pc0), 64'd1);

    // push + retire on empty
    do_reset();
    ea = rand_entry();
    step(1'b0, 1'b1, ea, 1'b1, 64'h0, 5'h0);
    chk("empty_pp_unf", 64'(un0), 64'd1);
    chk("empty_pp_pass", 64'(pc0), 64'd0);
    step(1'b0, 1'b0, '0, 1'b1, ea.result, ea.flags);
    chk("empty_pp_stored", 64'(pc0), 64'd1);

    // reset mid-run, then retire on empty
    do_reset();
    fill[0] = rand_entry();
    fill[1] = rand_entry();
    step(1'b0, 1'b1, fill[0], 1'b0, 64'h0, 5'h0);
    step(1'b0, 1'b1, fill[1], 1'b1, ~fill[0].result, fill[0].flags);
    step(1'b1, 1'b1, rand_entry(), 1'b1, fill[1].result, fill[1].flags);
    chk("midrst_fv", 64'(fv0), 64'd0);
    chk("midrst_fail", 64'(fc0), 64'd0);
    chk("midrst_diff", rd0, 64'h0);
    chk("midrst_stopped", 64'(st0), 64'd0);
    step(1'b0, 1'b0, '0, 1'b1, fill[1].result, fill[1].flags);
    chk("midrst_unf", 64'(un0), 64'd1);
    chk("midrst_pass", 64'(pc0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
